// File: rtl/mixcolumns_seq.sv
// Sequenced AES forward MixColumns: one table read per byte, XOR-combine.
// Start/busy/done handshake; 18-cycle latency from acceptance to done.
module mixcolumns_seq (
  input  logic         clock,
  input  logic         resetn,
  input  logic         start,
  input  logic [127:0] din,
  output logic [127:0] dout,
  output logic         busy,
  output logic         done,
  output logic [7:0]   rom_add,
  output logic         rom_en,
  input  logic [15:0]  rom_dout
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] COMB  = 2'd3;

  logic [1:0]   st;
  logic [3:0]   cnt;
  logic [127:0] state_reg;
  logic [15:0]  cap [16];
  logic [127:0] mixed;

  function automatic logic [7:0] byte_of(
    input logic [127:0] v,
    input logic [3:0]   i
  );
    logic [3:0] j;
    j = 4'd15 - i;
    return v[{j, 3'b000} +: 8];
  endfunction

  // Table request: only during RUN, addressed by the current byte.
  always_comb begin
    rom_en  = 1'b0;
    rom_add = 8'h00;
    if (st == RUN) begin
      rom_en  = 1'b1;
      rom_add = byte_of(state_reg, cnt);
    end
  end

  // Column combine from captured {2x,3x} words and raw bytes.
  always_comb begin
    logic [7:0] a  [4];
    logic [7:0] t2 [4];
    logic [7:0] t3 [4];
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = state_reg[8*(15-(4*c+r)) +: 8];
        t2[r] = cap[4*c+r][15:8];
        t3[r] = cap[4*c+r][7:0];
      end
      mixed[8*(15-4*c)     +: 8] = t2[0] ^ t3[1] ^ a[2]  ^ a[3];
      mixed[8*(15-4*c-1)   +: 8] = a[0]  ^ t2[1] ^ t3[2] ^ a[3];
      mixed[8*(15-4*c-2)   +: 8] = a[0]  ^ a[1]  ^ t2[2] ^ t3[3];
      mixed[8*(15-4*c-3)   +: 8] = t3[0] ^ a[1]  ^ a[2]  ^ t2[3];
    end
  end

  // Sequencer: accept, issue 16 reads, drain last word, combine.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st        <= IDLE;
      cnt       <= 4'd0;
      state_reg <= '0;
      dout      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < 16; i++) cap[i] <= 16'h0000;
    end else begin
      done <= 1'b0;
      case (st)
        IDLE: begin
          if (start) begin
            state_reg <= din;
            cnt       <= 4'd0;
            busy      <= 1'b1;
            st        <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 4'd1;
          if (cnt != 4'd0) cap[cnt - 4'd1] <= rom_dout;
          if (cnt == 4'd15) st <= DRAIN;
        end
        DRAIN: begin
          cap[15] <= rom_dout;
          st      <= COMB;
        end
        default: begin
          dout <= mixed;
          done <= 1'b1;
          busy <= 1'b0;
          st   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mixcolumns_seq.sv
// Bench for mixcolumns_seq: GF(2^8) reference model, table model,
// per-cycle output compare, directed vectors and random traffic.
module tb_mixcolumns_seq;

  logic         clock = 1'b0;
  logic         resetn;
  logic         start;
  logic [127:0] din;
  logic [127:0] dout;
  logic         busy;
  logic         done;
  logic [7:0]   rom_add;
  logic         rom_en;
  logic [15:0]  rom_dout = 16'h0000;

  int vectors = 0;
  int miscompares = 0;

  mixcolumns_seq dut (
    .clock(clock), .resetn(resetn), .start(start), .din(din),
    .dout(dout), .busy(busy), .done(done),
    .rom_add(rom_add), .rom_en(rom_en), .rom_dout(rom_dout)
  );

  always #5 clock = ~clock;

  function automatic logic [7:0] gmul(input logic [7:0] a,
                                      input logic [7:0] b);
    logic [7:0] p;
    logic       hi;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [15:0] romval(input logic [7:0] x);
    return {gmul(x, 8'h02), gmul(x, 8'h03)};
  endfunction

  function automatic logic [7:0] bsel(input logic [127:0] v, input int i);
    return v[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a [4];
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = bsel(s, 4*c+r);
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = gmul(a[r], 8'h02)
                              ^ gmul(a[(r+1)%4], 8'h03)
                              ^ a[(r+2)%4] ^ a[(r+3)%4];
    end
    return o;
  endfunction

  task automatic chk(input string n, input logic [127:0] act,
                     input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h at %0t", n, act, exp, $time);
    end
  endtask

  // Registered table: loads on enable, holds otherwise.
  always @(posedge clock)
    if (rom_en) rom_dout <= romval(rom_add);

  // Reference model: acceptance, age counter, result.
  bit           m_run = 0;
  bit           m_done = 0;
  int           m_age = 0;
  logic [127:0] m_src = '0;
  logic [127:0] m_dout = '0;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_run = 0; m_done = 0; m_age = 0;
      m_src = '0; m_dout = '0;
    end else begin
      m_done = 0;
      if (m_run) begin
        m_age++;
        if (m_age == 18) begin
          m_dout = mix(m_src);
          m_done = 1;
          m_run  = 0;
        end
      end else if (start) begin
        m_run = 1;
        m_age = 0;
        m_src = din;
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clock) begin
    logic       e_en;
    logic [7:0] e_add;
    e_en  = m_run && (m_age <= 15);
    e_add = e_en ? bsel(m_src, m_age) : 8'h00;
    chk("busy",    {127'b0, busy},   {127'b0, m_run});
    chk("done",    {127'b0, done},   {127'b0, m_done});
    chk("dout",    dout,             m_dout);
    chk("rom_en",  {127'b0, rom_en}, {127'b0, e_en});
    chk("rom_add", {120'b0, rom_add}, {120'b0, e_add});
    if (m_run && (m_age == 16 || m_age == 17))
      chk("rom_hold", {112'b0, rom_dout},
          {112'b0, romval(bsel(m_src, 15))});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input string n, output int lat);
    bit found;
    found = 0;
    lat   = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (done) begin
        found = 1;
        lat   = i;
        break;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL %s_timeout got no done want done", n);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] V1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] R1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V2 = 128'h2d26314c_00000000_ffffffff_01020304;
  localparam logic [127:0] R2 = 128'h4d7ebdf8_00000000_ffffffff_0304090a;

  initial begin
    int lat;
    logic [127:0] keep;
    resetn = 1'b0;
    start  = 1'b1;
    din    = V1;

    chk("gf_53", {112'b0, romval(8'h53)}, {112'b0, 16'ha6f5});
    chk("gf_db", {112'b0, romval(8'hdb)}, {112'b0, 16'had76});
    chk("mix_v1", mix(V1), R1);
    chk("mix_v2", mix(V2), R2);

    repeat (3) tick();
    chk("rst_dout", dout, '0);
    chk("rst_busy", {127'b0, busy}, '0);
    start  = 1'b0;
    resetn = 1'b1;
    tick();

    // FIPS vector, then back-to-back second vector in the done cycle.
    start = 1'b1;
    din   = V1;
    tick();
    start = 1'b0;
    din   = rnd128();
    wait_done("v1", lat);
    chk("v1_lat", 128'(lat), 128'd19);
    chk("v1_dout", dout, R1);
    start = 1'b1;
    din   = V2;
    @(posedge clock);
    #1;
    chk("b2b_busy", {127'b0, busy}, 128'd1);
    start = 1'b0;
    din   = rnd128();
    wait_done("v2", lat);
    chk("v2_lat", 128'(lat), 128'd19);
    chk("v2_dout", dout, R2);
    tick();

    // Start pulses and din changes while busy are ignored.
    keep  = rnd128();
    start = 1'b1;
    din   = keep;
    tick();
    for (int i = 0; i < 16; i++) begin
      start = 1'($urandom_range(0, 1));
      din   = rnd128();
      tick();
    end
    start = 1'b0;
    wait_done("busy_ign", lat);
    chk("busy_ign_dout", dout, mix(keep));
    repeat (3) tick();

    // Reset mid-run aborts with no done.
    start = 1'b1;
    din   = rnd128();
    tick();
    start = 1'b0;
    repeat (8) tick();
    resetn = 1'b0;
    #1;
    chk("abort_dout", dout, '0);
    chk("abort_busy", {127'b0, busy}, '0);
    chk("abort_en", {127'b0, rom_en}, '0);
    chk("abort_add", {120'b0, rom_add}, '0);
    repeat (2) tick();
    resetn = 1'b1;
    repeat (25) tick();

    // Fresh start after abort.
    keep  = rnd128();
    start = 1'b1;
    din   = keep;
    tick();
    start = 1'b0;
    wait_done("fresh", lat);
    chk("fresh_lat", 128'(lat), 128'd19);
    chk("fresh_dout", dout, mix(keep));

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      start = ($urandom_range(0, 3) == 0);
      din   = rnd128();
      tick();
    end
    start = 1'b0;
    repeat (25) tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
